// File: rtl/pdua_pkg.sv
// pdua_pkg: shared types and constants for the PDUA microsequencer.
// Holds the sequencer state enum, the microword sequencing-field positions,
// the MODE/COND encodings and the fixed block/step addresses.
// The IRQ state exists only when PDUA_USEQ_IRQ_EN is defined.
package pdua_pkg;
   localparam int END_BIT = 4;
   localparam int MODE_LO = 0;
   localparam int MODE_HI = 1;
   localparam int COND_LO = 2;
   localparam int COND_HI = 3;
   localparam logic [1:0] MODE_INC  = 2'b00;
   localparam logic [1:0] MODE_SKIP = 2'b11;
   localparam logic [1:0] COND_NONE = 2'b00;
   localparam logic [1:0] COND_Z    = 2'b01;
   localparam logic [1:0] COND_N    = 2'b10;
   localparam logic [1:0] COND_C    = 2'b11;
   localparam logic [4:0] FETCH_BLOCK = 5'h00;
   localparam logic [4:0] IRQ_BLOCK   = 5'h1B;
   localparam logic [2:0] SKIP_STEP   = 3'd3;
`ifdef PDUA_USEQ_IRQ_EN
   typedef enum logic [1:0] {FETCH, EXEC, IRQ} state_t;
`else
   typedef enum logic [1:0] {FETCH, EXEC} state_t;
`endif
endpackage

// File: rtl/pdua_cond_sel.sv
// pdua_cond_sel: picks the ALU flag named by a microword COND field.
// Ports: cond (COND field), flag_z/flag_n/flag_c (registered flags),
//        flag (selected flag; 0 for the never-true encoding).
module pdua_cond_sel
   import pdua_pkg::*;
(
   input  logic [1:0] cond,
   input  logic       flag_z,
   input  logic       flag_n,
   input  logic       flag_c,
   output logic       flag
);
   always_comb
      flag = (cond == COND_Z) ? flag_z :
             (cond == COND_N) ? flag_n :
             (cond == COND_C) ? flag_c : 1'b0;
endmodule

// File: rtl/pdua_useq.sv
// pdua_useq: PDUA control-unit microsequencer (fetch / execute / optional IRQ).
// Ports: clk, rst (sync active-high), hold (freeze), ir_opcode (IR[7:3]),
//        flag_z/flag_n/flag_c, uword (ROM word for uaddr), irq;
//        uaddr {block, step}, in_fetch, ucode_err pulse, irq_ack pulse.
// Macro PDUA_USEQ_IRQ_EN adds the interrupt block at 5'h1B; without it
// irq is ignored and irq_ack is tied low.
module pdua_useq
   import pdua_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        hold,
   input  logic [4:0]  ir_opcode,
   input  logic        flag_z,
   input  logic        flag_n,
   input  logic        flag_c,
   input  logic [26:0] uword,
   input  logic        irq,
   output logic [7:0]  uaddr,
   output logic        in_fetch,
   output logic        ucode_err,
   output logic        irq_ack
);
   state_t     state, state_nx;
   logic [2:0] step, step_nx;
   logic [4:0] blk;
   logic       flag, err_nx, ack_nx, skip;
   logic       unused_uword;
   assign unused_uword = ^uword[26:5];
   pdua_cond_sel u_cond_sel (
      .cond   (uword[COND_HI:COND_LO]),
      .flag_z (flag_z),
      .flag_n (flag_n),
      .flag_c (flag_c),
      .flag   (flag)
   );
   // A false condition jumps to the shared skip step, but only from the
   // leading steps; later conditional words fall through as increments.
   assign skip = (uword[MODE_HI:MODE_LO] == MODE_SKIP) && !flag && (step < SKIP_STEP);
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= FETCH;
         step      <= '0;
         ucode_err <= 1'b0;
      end else begin
         state     <= state_nx;
         step      <= step_nx;
         ucode_err <= err_nx;
      end
   end
`ifdef PDUA_USEQ_IRQ_EN
   always_ff @(posedge clk)
      irq_ack <= rst ? 1'b0 : ack_nx;
`else
   logic unused_irq;
   assign unused_irq = irq ^ ack_nx;
   assign irq_ack    = 1'b0;
`endif
   always_comb begin
      state_nx = state;
      step_nx  = step;
      err_nx   = 1'b0;
      ack_nx   = 1'b0;
      if (!hold) begin
         if (uword[END_BIT]) begin
            step_nx  = '0;
            state_nx = (state == FETCH) ? EXEC : FETCH;
`ifdef PDUA_USEQ_IRQ_EN
            if (state == EXEC && irq) begin
               state_nx = IRQ;
               ack_nx   = 1'b1;
            end
`endif
         end else if (step == 3'd7) begin
            state_nx = FETCH;
            step_nx  = '0;
            err_nx   = 1'b1;
         end else
            step_nx = skip ? SKIP_STEP : step + 3'd1;
      end
   end
   always_comb begin
      blk = (state == EXEC) ? ir_opcode : FETCH_BLOCK;
`ifdef PDUA_USEQ_IRQ_EN
      if (state == IRQ) blk = IRQ_BLOCK;
`endif
      uaddr    = {blk, step};
      in_fetch = (state == FETCH);
   end
endmodule

// File: tb/tb_pdua_useq.sv
// tb_pdua_useq: directed and randomized checks of pdua_useq against a
// behavioural model driven by a ROM array held in the bench.
module tb_pdua_useq;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        hold = 1'b0;
   logic [4:0]  ir_opcode = '0;
   logic        flag_z = 1'b0, flag_n = 1'b0, flag_c = 1'b0;
   logic        irq = 1'b0;
   logic [26:0] uword;
   logic [7:0]  uaddr;
   logic        in_fetch, ucode_err, irq_ack;
   logic [26:0] rom [256];
   int          n_tests = 0, n_fail = 0;
   int          m_kind = 0, m_step = 0;
   bit          m_err = 1'b0, m_ack = 1'b0;
   bit          irq_en;
   localparam logic [26:0] W_END = 27'h10;
   always #5 clk = ~clk;
   assign uword = rom[uaddr];
   pdua_useq dut (
      .clk       (clk),
      .rst       (rst),
      .hold      (hold),
      .ir_opcode (ir_opcode),
      .flag_z    (flag_z),
      .flag_n    (flag_n),
      .flag_c    (flag_c),
      .uword     (uword),
      .irq       (irq),
      .uaddr     (uaddr),
      .in_fetch  (in_fetch),
      .ucode_err (ucode_err),
      .irq_ack   (irq_ack)
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask
   // Model address: kind 0 = fetch routine, 1 = opcode routine, 2 = interrupt routine.
   function automatic int m_addr();
      return (m_kind == 0) ? m_step : (m_kind == 1) ? ir_opcode * 8 + m_step : 8'hD8 + m_step;
   endfunction
   task automatic adv();
      logic [26:0] w;
      logic [3:0]  fl;
      int          nk, ns;
      bit          ne, na;
      w  = rom[m_addr()];
      fl = {flag_c, flag_n, flag_z, 1'b0};
      nk = m_kind; ns = m_step; ne = 1'b0; na = 1'b0;
      if (rst) begin
         nk = 0; ns = 0;
      end else if (!hold) begin
         if (w[4]) begin
            ns = 0;
            if (m_kind == 0) nk = 1;
            else if (irq_en && m_kind == 1 && irq) begin nk = 2; na = 1'b1; end
            else nk = 0;
         end else if (m_step == 7) begin
            nk = 0; ns = 0; ne = 1'b1;
         end else if (w[1:0] == 2'b11 && !fl[w[3:2]] && m_step < 3)
            ns = 3;
         else
            ns = m_step + 1;
      end
      @(posedge clk);
      #1;
      m_kind = nk; m_step = ns; m_err = ne; m_ack = na;
      chk("uaddr_model", uaddr, m_addr());
      chk("in_fetch_model", in_fetch, m_kind == 0);
      chk("ucode_err_model", ucode_err, m_err);
      chk("irq_ack_model", irq_ack, m_ack);
   endtask
   task automatic do_reset();
      rst = 1'b1; hold = 1'b0;
      adv();
      rst = 1'b0;
   endtask
   task automatic clear_rom();
      for (int i = 0; i < 256; i++) rom[i] = '0;
      rom[2] = W_END;
   endtask
   initial begin
`ifdef PDUA_USEQ_IRQ_EN
      irq_en = 1'b1;
`else
      irq_en = 1'b0;
`endif
      clear_rom();
      rom[8'h08] = W_END;
      rom[8'h58] = 27'h07; rom[8'h59] = '0; rom[8'h5A] = W_END; rom[8'h5B] = W_END;
      rom[8'h68] = 27'h0F; rom[8'h69] = W_END; rom[8'h6B] = W_END;
      rom[8'h1A] = W_END;
      rom[8'hD9] = W_END;
      ir_opcode = 5'h01;
      do_reset();
      chk("rst_uaddr", uaddr, 8'h00);
      chk("rst_in_fetch", in_fetch, 1'b1);
      chk("rst_err", ucode_err, 1'b0);
      chk("rst_ack", irq_ack, 1'b0);
      adv(); chk("mov_1", uaddr, 8'h01); chk("mov_fetch1", in_fetch, 1'b1);
      adv(); chk("mov_2", uaddr, 8'h02); chk("mov_fetch2", in_fetch, 1'b1);
      adv(); chk("mov_3", uaddr, 8'h08); chk("mov_fetch3", in_fetch, 1'b0);
      adv(); chk("mov_4", uaddr, 8'h00);
      ir_opcode = 5'h0B; flag_z = 1'b1;
      repeat (3) adv();
      chk("jz_t0", uaddr, 8'h58);
      adv(); chk("jz_t1", uaddr, 8'h59);
      adv(); chk("jz_t2", uaddr, 8'h5A);
      adv(); chk("jz_t3", uaddr, 8'h00);
      flag_z = 1'b0;
      repeat (3) adv();
      adv(); chk("jz_n1", uaddr, 8'h5B);
      adv(); chk("jz_n2", uaddr, 8'h00);
      ir_opcode = 5'h0D; flag_c = 1'b0; flag_z = 1'b1;
      repeat (3) adv();
      chk("jc_0", uaddr, 8'h68);
      adv(); chk("jc_skip", uaddr, 8'h6B);
      adv(); flag_c = 1'b1;
      repeat (3) adv();
      adv(); chk("jc_taken", uaddr, 8'h69);
      adv(); ir_opcode = 5'h03; flag_c = 1'b0;
      chk("pre_hold", uaddr, 8'h00);
      repeat (4) adv();
      chk("hold_at", uaddr, 8'h19);
      hold = 1'b1;
      for (int i = 0; i < 3; i++) begin adv(); chk("hold_keep", uaddr, 8'h19); end
      hold = 1'b0;
      adv(); chk("hold_release", uaddr, 8'h1A);
      adv(); ir_opcode = 5'h1F;
      repeat (3) adv();
      for (int i = 0; i < 8; i++) begin
         chk("ovf_run", uaddr, 8'hF8 + i);
         chk("ovf_noerr", ucode_err, 1'b0);
         if (i < 7) adv();
      end
      adv(); chk("ovf_addr", uaddr, 8'h00); chk("ovf_err", ucode_err, 1'b1);
      adv(); chk("ovf_err_clear", ucode_err, 1'b0);
      ir_opcode = 5'h01; irq = 1'b1;
      do_reset();
      repeat (3) adv();
      chk("irq_end_word", uaddr, 8'h08);
      adv();
      chk("irq_enter", uaddr, irq_en ? 8'hD8 : 8'h00);
      chk("irq_ack", irq_ack, irq_en);
      if (irq_en) begin
         adv(); chk("irq_step1", uaddr, 8'hD9); chk("irq_ack_clear", irq_ack, 1'b0);
         adv(); chk("irq_return", uaddr, 8'h00);
         repeat (5) adv();
         chk("irq_again", uaddr, 8'hD9);
         rst = 1'b1; adv(); rst = 1'b0;
         chk("irq_rst", uaddr, 8'h00);
         chk("irq_rst_ack", irq_ack, 1'b0);
      end
      irq = 1'b0;
      for (int i = 0; i < 256; i++) begin
         rom[i] = 27'($urandom);
         rom[i][4] = ($urandom_range(2) == 0);
      end
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         rst    = ($urandom_range(59) == 0);
         hold   = !rst && ($urandom_range(4) == 0);
         irq    = ($urandom_range(2) == 0);
         flag_z = 1'($urandom); flag_n = 1'($urandom); flag_c = 1'($urandom);
         if (m_kind == 0) ir_opcode = 5'($urandom);
         adv();
      end
      rst = 1'b0; hold = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
